// File: rtl/cond_check_pkg.sv
// Shared definitions for the condition-check block: condition codes, NZCV bit positions, response FSM states.
package cond_check_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Same order as the ALU flag generator output: {N,Z,C,V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/cond_check_cond_eval.sv
// Combinational condition evaluator: (cond, nzcv) -> pass, no state, no latency.
module cond_eval
  import cond_check_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic base;
  logic n_ne_v;

  assign n_ne_v = nzcv[FLAG_N] ^ nzcv[FLAG_V];

  // Codes come in pairs: the even code is the base test, the odd code its inverse.
  always_comb begin
    base = 1'b1;
    case (cond)
      COND_EQ, COND_NE: base = nzcv[FLAG_Z];
      COND_CS, COND_CC: base = nzcv[FLAG_C];
      COND_MI, COND_PL: base = nzcv[FLAG_N];
      COND_VS, COND_VC: base = nzcv[FLAG_V];
      COND_HI, COND_LS: base = nzcv[FLAG_C] & ~nzcv[FLAG_Z];
      COND_GE, COND_LT: base = ~n_ne_v;
      COND_GT, COND_LE: base = ~nzcv[FLAG_Z] & ~n_ne_v;
      COND_AL, COND_NV: base = 1'b1;
      default:          base = 1'b1;
    endcase
  end

  assign pass = base ^ cond[0];

endmodule

// File: rtl/cond_check.sv
// Condition check against NZCV with pending-write interlock; 1-cycle latency; one-entry response
// register stalls requests while flags are pending or a response is held unaccepted.
module cond_check
  import cond_check_pkg::*;
#(
  parameter int PEND_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flags_we,
  input  logic [3:0] flags_in,
  input  logic       pend_inc,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_cond,
  input  logic [3:0] req_tag,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_pass,
  output logic [3:0] resp_tag,
  output logic [3:0] flags_q,
  output logic       pend_err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0] pend_cnt;
  logic [3:0]        eff_flags;
  logic              flags_stable;
  logic              accept;
  logic              eval_pass;
  state_t            state;
  state_t            state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (flags_we) begin
      flags_q <= flags_in;
    end
  end

  // A write with nothing pending is a direct write and leaves the count at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt <= '0;
      pend_err <= 1'b0;
    end else if (pend_inc && !flags_we) begin
      if (pend_cnt == PEND_MAX) begin
        pend_err <= 1'b1;
      end else begin
        pend_cnt <= pend_cnt + PEND_ONE;
      end
    end else if (flags_we && !pend_inc && (pend_cnt != '0)) begin
      pend_cnt <= pend_cnt - PEND_ONE;
    end
  end

  assign eff_flags    = flags_we ? flags_in : flags_q;
  assign flags_stable = (pend_cnt == '0) ||
                        ((pend_cnt == PEND_ONE) && flags_we && !pend_inc);
  assign req_ready    = flags_stable && (!resp_valid || resp_ready);
  assign accept       = req_valid && req_ready;

  cond_eval u_cond_eval (
    .cond (req_cond),
    .nzcv (eff_flags),
    .pass (eval_pass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (resp_ready && !accept) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  assign resp_valid = (state == ST_FULL);

  // Result is captured at accept, so later flag writes cannot disturb a held response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_pass <= 1'b0;
      resp_tag  <= 4'h0;
    end else if (accept) begin
      resp_pass <= eval_pass;
      resp_tag  <= req_tag;
    end
  end

endmodule

// File: tb/tb_cond_check.sv
// Scoreboard bench for cond_check: directed vectors, expected responses queued at accept, checked at delivery.
module tb_cond_check;
  import cond_check_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flags_we = 1'b0;
  logic [3:0] flags_in = 4'h0;
  logic       pend_inc = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_cond = 4'h0;
  logic [3:0] req_tag = 4'h0;
  logic       resp_valid;
  logic       resp_ready = 1'b1;
  logic       resp_pass;
  logic [3:0] resp_tag;
  logic [3:0] flags_q;
  logic       pend_err;

  always #5 clk = ~clk;

  cond_check #(.PEND_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flags_we   (flags_we),
    .flags_in   (flags_in),
    .pend_inc   (pend_inc),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cond   (req_cond),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_pass  (resp_pass),
    .resp_tag   (resp_tag),
    .flags_q    (flags_q),
    .pend_err   (pend_err)
  );

  typedef struct packed {
    logic       pass;
    logic [3:0] tag;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mflags;
  int         n_chk = 0;
  int         n_fail = 0;

  // Flat condition table, one entry per code.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flags_we  = 1'b0;
    pend_inc  = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        sb.delete();
        mflags = 4'h0;
      end else begin
        if (resp_valid && resp_ready) begin
          chk("sb_nonempty", (sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("resp_pass", resp_pass, e.pass);
            chk("resp_tag", resp_tag, e.tag);
          end
        end
        if (req_valid && req_ready)
          sb.push_back(exp_t'{ref_pass(req_cond, flags_we ? flags_in : mflags), req_tag});
        if (flags_we) mflags = flags_in;
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    tick();
    @(negedge clk);
    chk("rst_flags_q", flags_q, 4'h0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_pass", resp_pass, 0);
    chk("rst_resp_tag", resp_tag, 4'h0);
    chk("rst_pend_err", pend_err, 0);
    chk("rst_req_ready", req_ready, 1);
    tick();
    rst_n = 1'b1;

    // All 16 conditions against all 16 flag values, back to back
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        tick();
        flags_we  = 1'b1;
        flags_in  = f[3:0];
        req_valid = 1'b1;
        req_cond  = c[3:0];
        req_tag   = f[3:0];
      end
    end
    tick();
    idle();
    @(negedge clk);
    chk("walk_flags_q", flags_q, 4'hF);

    // Same-cycle forwarding
    tick();
    flags_we = 1'b1;
    flags_in = 4'b0100;
    tick();
    flags_in  = 4'b0000;
    req_valid = 1'b1;
    req_cond  = COND_EQ;
    req_tag   = 4'd5;
    tick();
    idle();
    @(negedge clk);
    chk("fwd_resp_valid", resp_valid, 1);
    chk("fwd_resp_pass", resp_pass, 0);
    chk("fwd_resp_tag", resp_tag, 4'd5);
    chk("fwd_flags_q", flags_q, 4'b0000);

    // Two pending writes interlock the request
    tick();
    pend_inc = 1'b1;
    tick();
    tick();
    pend_inc  = 1'b0;
    req_valid = 1'b1;
    req_cond  = COND_EQ;
    req_tag   = 4'd6;
    @(negedge clk);
    chk("pend2_ready", req_ready, 0);
    tick();
    flags_we = 1'b1;
    flags_in = 4'b0000;
    @(negedge clk);
    chk("pend_first_we_ready", req_ready, 0);
    tick();
    flags_in = 4'b0100;
    @(negedge clk);
    chk("pend_last_we_ready", req_ready, 1);
    tick();
    idle();
    @(negedge clk);
    chk("pend_resp_valid", resp_valid, 1);
    chk("pend_resp_pass", resp_pass, 1);
    chk("pend_resp_tag", resp_tag, 4'd6);

    // Held response is immune to later flag writes
    tick();
    resp_ready = 1'b0;
    flags_we   = 1'b1;
    flags_in   = 4'b0000;
    req_valid  = 1'b1;
    req_cond   = COND_GT;
    req_tag    = 4'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      flags_in = 4'b0100;
      req_cond = COND_AL;
      req_tag  = 4'd8;
      @(negedge clk);
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_resp_pass", resp_pass, 1);
      chk("hold_resp_tag", resp_tag, 4'd7);
      chk("hold_req_ready", req_ready, 0);
    end
    tick();
    flags_we   = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("release_req_ready", req_ready, 1);
    tick();
    idle();
    @(negedge clk);
    chk("release_next_tag", resp_tag, 4'd8);

    // Four back-to-back requests, one response per cycle
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k < 4) begin
        req_valid = 1'b1;
        req_cond  = (k == 1) ? COND_NV : COND_AL;
        req_tag   = 4'(k + 1);
      end else begin
        idle();
      end
      @(negedge clk);
      if (k < 4) chk("b2b_req_ready", req_ready, 1);
      if (k >= 1) begin
        chk("b2b_resp_valid", resp_valid, 1);
        chk("b2b_resp_tag", resp_tag, 4'(k));
      end
    end
    tick();
    @(negedge clk);
    chk("b2b_drained", resp_valid, 0);

    // Counter saturation, then async reset while FULL
    tick();
    resp_ready = 1'b0;
    flags_we   = 1'b1;
    flags_in   = 4'b1010;
    tick();
    flags_we  = 1'b0;
    req_valid = 1'b1;
    req_cond  = COND_LT;
    req_tag   = 4'd10;
    tick();
    req_valid = 1'b0;
    pend_inc  = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      @(negedge clk);
      chk("pend_err_pre", pend_err, 0);
    end
    tick();
    pend_inc = 1'b0;
    @(negedge clk);
    chk("pend_err_set", pend_err, 1);
    chk("sat_held_tag", resp_tag, 4'd10);
    tick();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_cond   = COND_AL;
    req_tag    = 4'd11;
    @(negedge clk);
    chk("cnt7_ready", req_ready, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      flags_we = 1'b1;
      flags_in = 4'b0011;
      @(negedge clk);
      chk("drain_ready", req_ready, 0);
    end
    tick();
    @(negedge clk);
    chk("cnt1_we_ready", req_ready, 1);
    tick();
    idle();
    resp_ready = 1'b0;
    @(negedge clk);
    chk("full_resp_valid", resp_valid, 1);
    chk("full_resp_tag", resp_tag, 4'd11);
    chk("err_sticky", pend_err, 1);
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_resp_pass", resp_pass, 0);
    chk("arst_flags_q", flags_q, 4'h0);
    chk("arst_pend_err", pend_err, 0);
    #1;
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_cond   = COND_EQ;
    req_tag    = 4'd9;
    @(negedge clk);
    chk("post_rst_no_resp", resp_valid, 0);
    chk("post_rst_ready", req_ready, 1);
    tick();
    idle();
    @(negedge clk);
    chk("first_accept_valid", resp_valid, 1);
    chk("first_accept_tag", resp_tag, 4'd9);
    chk("first_accept_pass", resp_pass, 0);

    repeat (3) tick();
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
